// File: rtl/ioshim_pkg.sv
// Shared ioshim definitions: host command opcodes, the error response byte
// and the command engine state encoding.
package ioshim_pkg;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam logic [7:0] ERR_BYTE = 8'hEE;

    typedef enum logic [1:0] {
        IDLE,
        WDATA,
        RESP
    } state_t;

endpackage

// File: rtl/ioshim_hostcmd.sv
// Host command engine: parses a byte stream of read/write commands and drives
// the ioshim register file ports, returning read data on a response stream.
// Command byte: [7:6] opcode, [5:4] transfers-1, [3:0] start address.
module ioshim_hostcmd
    import ioshim_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       reg_wr_en,
    output logic [3:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    output logic [3:0] reg_rd_addr,
    input  logic [7:0] reg_rd_data,
    output logic       busy
);

    state_t     state;
    state_t     next_state;
    logic [3:0] addr;
    logic [1:0] count;
    logic       rsv;

    logic       in_accept;
    logic       resp_load;
    logic       resp_done;
    logic [1:0] opcode;

    assign opcode      = in_data[7:6];
    assign in_ready    = (state != RESP);
    assign busy        = (state != IDLE);
    assign in_accept   = in_valid && in_ready;
    assign reg_rd_addr = addr;

    // A response byte is loaded on the first RESP cycle and again on each
    // handshake that still has bytes left; the final handshake ends the burst.
    assign resp_load = (state == RESP) && (!out_valid || (out_ready && count != 2'd0));
    assign resp_done = (state == RESP) && out_valid && out_ready && (count == 2'd0);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode from accepted command bytes and response handshakes.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in_accept) begin
                    case (opcode)
                        OP_WR:   next_state = WDATA;
                        OP_RD:   next_state = RESP;
                        OP_RSV:  next_state = RESP;
                        default: next_state = IDLE;
                    endcase
                end
            end
            WDATA: begin
                if (in_accept && count == 2'd0) begin
                    next_state = IDLE;
                end
            end
            RESP: begin
                if (resp_done) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Address/count tracking, registered write strobe and response byte.
    // The response byte is only reloaded on a handshake, so it stays stable
    // under backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr        <= 4'd0;
            count       <= 2'd0;
            rsv         <= 1'b0;
            reg_wr_en   <= 1'b0;
            reg_wr_addr <= 4'd0;
            reg_wr_data <= 8'h00;
            out_valid   <= 1'b0;
            out_data    <= 8'h00;
        end else begin
            reg_wr_en <= 1'b0;
            if (state == IDLE && in_accept && opcode != OP_NOP) begin
                addr  <= in_data[3:0];
                count <= (opcode == OP_RSV) ? 2'd0 : in_data[5:4];
                rsv   <= (opcode == OP_RSV);
            end
            if (state == WDATA && in_accept) begin
                reg_wr_en   <= 1'b1;
                reg_wr_addr <= addr;
                reg_wr_data <= in_data;
                addr        <= addr + 4'd1;
                if (count != 2'd0) begin
                    count <= count - 2'd1;
                end
            end
            if (resp_load) begin
                out_valid <= 1'b1;
                out_data  <= rsv ? ERR_BYTE : reg_rd_data;
                if (!rsv) begin
                    addr <= addr + 4'd1;
                end
                if (out_valid) begin
                    count <= count - 2'd1;
                end
            end
            if (resp_done) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ioshim_hostcmd.sv
// Directed self-checking bench for ioshim_hostcmd with a behavioural 16x8
// register file (combinational read with write bypass) beside the DUT.
module tb_ioshim_hostcmd;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       reg_wr_en;
    logic [3:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic [3:0] reg_rd_addr;
    logic [7:0] reg_rd_data;
    logic       busy;

    int check_count = 0;
    int pass_count  = 0;
    int cycle       = 0;

    logic [7:0] mem [16];
    logic [7:0] rx_q [$];
    logic [3:0] wr_addr_q [$];
    logic [7:0] wr_data_q [$];
    int         wr_cyc_q [$];

    ioshim_hostcmd dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .reg_rd_addr (reg_rd_addr),
        .reg_rd_data (reg_rd_data),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model; contents survive engine reset.
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    end
    always @(posedge clk) begin
        if (reg_wr_en) mem[reg_wr_addr] <= reg_wr_data;
        cycle <= cycle + 1;
    end
    assign reg_rd_data = (reg_wr_en && reg_wr_addr == reg_rd_addr) ? reg_wr_data : mem[reg_rd_addr];

    // Log every write strobe seen between clock edges.
    always @(negedge clk) begin
        if (reg_wr_en) begin
            wr_addr_q.push_back(reg_wr_addr);
            wr_data_q.push_back(reg_wr_data);
            wr_cyc_q.push_back(cycle);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Drive a back-to-back byte sequence starting at a falling edge.
    task automatic applyStimulus(input logic [7:0] bytes [$]);
        foreach (bytes[i]) begin
            in_valid = 1'b1;
            in_data  = bytes[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    // Collect n response bytes; optionally stall out_ready once stall_after
    // bytes have been taken, checking the presented byte stays put.
    task automatic collectResponse(input int n, input int stall_after, input int stall_len);
        int   budget;
        logic stalled;
        logic [7:0] held;
        budget  = 0;
        stalled = 1'b0;
        rx_q.delete();
        out_ready = 1'b1;
        while (rx_q.size() < n && budget < 200) begin
            @(negedge clk);
            budget++;
            checkOutput("resp_in_ready", {31'd0, in_ready}, 32'd0);
            if (out_valid) begin
                if (!stalled && stall_len > 0 && rx_q.size() == stall_after) begin
                    out_ready = 1'b0;
                    held      = out_data;
                    for (int k = 0; k < stall_len; k++) begin
                        @(negedge clk);
                        checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
                        checkOutput("stall_data", {24'd0, out_data}, {24'd0, held});
                    end
                    out_ready = 1'b1;
                    stalled   = 1'b1;
                end
                rx_q.push_back(out_data);
            end
        end
        checkOutput("resp_count", rx_q.size(), n);
    endtask

    initial begin
        logic [7:0] seq [$];
        logic [7:0] exp_rd [4];
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset values
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out_data", {24'd0, out_data}, 32'h00);
        checkOutput("rst_wr_en", {31'd0, reg_wr_en}, 32'd0);
        checkOutput("rst_wr_addr", {28'd0, reg_wr_addr}, 32'd0);
        checkOutput("rst_rd_addr", {28'd0, reg_rd_addr}, 32'd0);

        // Four-byte write burst at address 3
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        seq = '{8'h73, 8'h11, 8'h22, 8'h33, 8'h44};
        applyStimulus(seq);
        repeat (2) @(negedge clk);
        checkOutput("wr_pulses", wr_addr_q.size(), 4);
        if (wr_addr_q.size() == 4) begin
            checkOutput("wr0_addr", {28'd0, wr_addr_q[0]}, 32'd3);
            checkOutput("wr0_data", {24'd0, wr_data_q[0]}, 32'h11);
            checkOutput("wr1_addr", {28'd0, wr_addr_q[1]}, 32'd4);
            checkOutput("wr1_data", {24'd0, wr_data_q[1]}, 32'h22);
            checkOutput("wr2_addr", {28'd0, wr_addr_q[2]}, 32'd5);
            checkOutput("wr2_data", {24'd0, wr_data_q[2]}, 32'h33);
            checkOutput("wr3_addr", {28'd0, wr_addr_q[3]}, 32'd6);
            checkOutput("wr3_data", {24'd0, wr_data_q[3]}, 32'h44);
            checkOutput("wr_back_to_back", wr_cyc_q[3] - wr_cyc_q[0], 32'd3);
        end
        checkOutput("wr_done_busy", {31'd0, busy}, 32'd0);
        checkOutput("wr_done_en", {31'd0, reg_wr_en}, 32'd0);

        // Address wrap 0xF -> 0x0
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        seq = '{8'h5F, 8'hAA, 8'hBB};
        applyStimulus(seq);
        repeat (2) @(negedge clk);
        checkOutput("wrap_pulses", wr_addr_q.size(), 2);
        if (wr_addr_q.size() == 2) begin
            checkOutput("wrap0_addr", {28'd0, wr_addr_q[0]}, 32'hF);
            checkOutput("wrap0_data", {24'd0, wr_data_q[0]}, 32'hAA);
            checkOutput("wrap1_addr", {28'd0, wr_addr_q[1]}, 32'h0);
            checkOutput("wrap1_data", {24'd0, wr_data_q[1]}, 32'hBB);
        end

        // Read burst with a 3-cycle stall after the second byte
        exp_rd = '{8'h11, 8'h22, 8'h33, 8'h44};
        seq = '{8'hB3};
        applyStimulus(seq);
        collectResponse(4, 2, 3);
        for (int i = 0; i < 4; i++) begin
            if (i < rx_q.size()) checkOutput($sformatf("rd%0d", i), {24'd0, rx_q[i]}, {24'd0, exp_rd[i]});
        end
        @(negedge clk);
        checkOutput("rd_done_busy", {31'd0, busy}, 32'd0);
        checkOutput("rd_done_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rd_done_valid", {31'd0, out_valid}, 32'd0);

        // NOP: consumed, nothing returned
        seq = '{8'h00};
        applyStimulus(seq);
        checkOutput("nop_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("nop_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        checkOutput("nop_out_valid", {31'd0, out_valid}, 32'd0);

        // Reserved opcode returns a single error byte
        seq = '{8'hC5};
        applyStimulus(seq);
        collectResponse(1, 0, 0);
        if (rx_q.size() == 1) checkOutput("rsv_byte", {24'd0, rx_q[0]}, 32'hEE);
        @(negedge clk);
        checkOutput("rsv_done_busy", {31'd0, busy}, 32'd0);
        checkOutput("rsv_done_valid", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a read burst
        seq = '{8'hB3};
        applyStimulus(seq);
        collectResponse(2, 0, 0);
        if (rx_q.size() == 2) begin
            checkOutput("mid_rd0", {24'd0, rx_q[0]}, 32'h11);
            checkOutput("mid_rd1", {24'd0, rx_q[1]}, 32'h22);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("mid_rst_wr_en", {31'd0, reg_wr_en}, 32'd0);
        checkOutput("mid_rst_data", {24'd0, out_data}, 32'h00);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        seq = '{8'h83};
        applyStimulus(seq);
        collectResponse(1, 0, 0);
        if (rx_q.size() == 1) checkOutput("post_rst_rd", {24'd0, rx_q[0]}, 32'h11);
        @(negedge clk);
        checkOutput("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
